llc_cmd_queue: RTL and testbench
================================

# llc_cmd_queue

Front-end command stage directly upstream of the LLC controller. Accepts trace commands (function code + 32-bit address), drops illegal function codes, buffers legal commands in a small FIFO, and presents each one already split into tag/index/byte-select with command-class flags. Decouples the trace reader from controller stalls and keeps saturating command statistics.

## Interface
Parameters (geometry widths come from `ParameterDefinitions`):
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `LVL_W`, `$clog2(DEPTH+1)`, width of `level`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  upstream command valid.
- `in_ready`  out  1  stage can accept; `!full`.
- `in_func`  in  FUNCTION_SIZE  function code.
- `in_addr`  in  ADDRESS_SIZE  byte address.
- `out_valid`  out  1  head entry valid; `!empty`.
- `out_ready`  in  1  controller consumes head.
- `out_func`  out  FUNCTION_SIZE  head function code.
- `out_tag`  out  TAG_SIZE  `addr[31:21]`.
- `out_index`  out  INDEX_SIZE  `addr[20:6]`.
- `out_offset`  out  BYTE_SELECT_SIZE  `addr[5:0]`.
- `out_snoop`  out  1  head code in 3..6.
- `out_maint`  out  1  head code is 8 or 9.
- `accepted_count`  out  COUNTER_SIZE  legal commands enqueued.
- `illegal_count`  out  COUNTER_SIZE  illegal commands dropped.
- `level`  out  LVL_W  current occupancy.

## Operation
- Legal codes: 0 read, 1 write, 2 instr read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RWIM, 8 clear/reset, 9 print. Illegal: 7, 10–15.
- Accept = `in_valid && in_ready`. Legal + accept → write {func, addr} at write pointer, `accepted_count`++. Illegal + accept → nothing written, `illegal_count`++. The handshake completes in both cases.
- `in_ready` depends only on FIFO state, never on `in_func`. When full, illegal commands also stall.
- Pop = `out_valid && out_ready`. Outputs reflect the head entry and are decoded combinationally from registered storage.
- Codes 8/9 pass through in order and act as barriers only by position. The queue never reorders or merges entries.
- Counters saturate at `2^COUNTER_SIZE-1` and do not wrap.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty comes from `level`.

## Timing
- Reset (`rst` high at a `clk` edge): `level`=0, both pointers 0, `out_valid`=0, `in_ready`=1, both counters 0. Data outputs are don't-care while `out_valid`=0. Reset wins over a simultaneous accept or pop. An in-flight command is lost.
- Latency: a command accepted at edge N gives `out_valid`=1 after edge N. There is no same-cycle bypass.
- Push and pop in the same cycle: `level` is unchanged and both pointers advance. Because `in_ready`=0 when full, a pop on a full queue frees a slot that is usable only from the next cycle.
- Illegal accept together with a pop: `level` decrements.
- While `out_valid`=1 and `out_ready`=0, all `out_*` fields hold stable.

## Structure
- The package gains: the `llc_func_e` enum (codes above), `is_legal_func`/`is_snoop_func` functions, and an `llc_cmd_t` struct {func, tag, index, offset}.
- One sub-module, `llc_cmd_fifo`: a generic valid/ready synchronous FIFO, parameterised on width/depth, that exports `level`. Decode, drop and counters stay in `llc_cmd_queue`.

## Test plan
- Reset, then accept func=0, addr=0x12345678 → next cycle `out_valid`=1, tag=0x091, index=0x5159, offset=0x38, snoop=0, maint=0, `accepted_count`=1.
- Send func=7 then func=4 addr=0x00000040 → only one entry queued; head func=4, index=0x0001, snoop=1; `illegal_count`=1.
- Hold `out_ready`=0 and push 5 legal commands → `in_ready` drops after the 4th, `level`=4, the 5th stalls; one pop then accepts it the cycle after the pop.
- Continuous push+pop at `level`=2 for 20 cycles → `level` stays 2; outputs in FIFO order across pointer wrap.
- Preload `accepted_count` near saturation (drive 65,540 legal accepts with continuous pop) → count sticks at 0xFFFF.
- Assert `rst` with 3 entries queued and a simultaneous push → next cycle `level`=0, `out_valid`=0, counters 0.

Source files
------------

// File: rtl/llc_cmd_queue_pkg.sv
// llc_cmd_queue_pkg
// Shared geometry, function-code enum, decoded-command struct and helpers
// for the LLC command front-end. No ports (package).
package llc_cmd_queue_pkg;

  localparam int ADDRESS_SIZE     = 32;
  localparam int FUNCTION_SIZE    = 4;
  localparam int TAG_SIZE         = 11;
  localparam int INDEX_SIZE       = 15;
  localparam int BYTE_SELECT_SIZE = 6;
  localparam int COUNTER_SIZE     = 16;
  localparam int CMD_W            = FUNCTION_SIZE + ADDRESS_SIZE;

  typedef enum logic [FUNCTION_SIZE-1:0] {
    FN_READ     = 4'd0,
    FN_WRITE    = 4'd1,
    FN_IREAD    = 4'd2,
    FN_SNP_INV  = 4'd3,
    FN_SNP_RD   = 4'd4,
    FN_SNP_WR   = 4'd5,
    FN_SNP_RWIM = 4'd6,
    FN_CLEAR    = 4'd8,
    FN_PRINT    = 4'd9
  } llc_func_e;

  typedef struct packed {
    logic [FUNCTION_SIZE-1:0]    func;
    logic [TAG_SIZE-1:0]         tag;
    logic [INDEX_SIZE-1:0]       index;
    logic [BYTE_SELECT_SIZE-1:0] offset;
  } llc_cmd_t;

  function automatic logic is_legal_func(input logic [FUNCTION_SIZE-1:0] f);
    case (llc_func_e'(f))
      FN_READ, FN_WRITE, FN_IREAD, FN_SNP_INV, FN_SNP_RD,
      FN_SNP_WR, FN_SNP_RWIM, FN_CLEAR, FN_PRINT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_snoop_func(input logic [FUNCTION_SIZE-1:0] f);
    return (f >= FN_SNP_INV) && (f <= FN_SNP_RWIM);
  endfunction

  function automatic logic is_maint_func(input logic [FUNCTION_SIZE-1:0] f);
    return (f == FN_CLEAR) || (f == FN_PRINT);
  endfunction

  function automatic llc_cmd_t split_cmd(input logic [FUNCTION_SIZE-1:0] f,
                                         input logic [ADDRESS_SIZE-1:0]  a);
    llc_cmd_t c;
    c.func   = f;
    c.tag    = a[ADDRESS_SIZE-1 -: TAG_SIZE];
    c.index  = a[BYTE_SELECT_SIZE +: INDEX_SIZE];
    c.offset = a[BYTE_SELECT_SIZE-1:0];
    return c;
  endfunction

endpackage

// File: rtl/llc_cmd_fifo.sv
// llc_cmd_fifo
// Generic synchronous valid/ready FIFO. Full/empty derive from the occupancy
// count; pointers wrap naturally (DEPTH must be a power of two).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_push_valid/o_push_ready/i_push_data   write side
//   o_pop_valid/i_pop_ready/o_pop_data      read side (head entry)
//   o_level                  current occupancy
module llc_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_push_ready = (r_level != LVL_W'(DEPTH));
  assign o_pop_valid  = (r_level != '0);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;
  assign o_pop_data   = r_mem[r_rd_ptr];
  assign o_level      = r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/llc_cmd_queue.sv
// llc_cmd_queue
// Command stage in front of the LLC controller: drops illegal function codes,
// buffers legal commands, presents the head split into tag/index/offset with
// class flags, and keeps saturating accept/drop statistics.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_func/in_addr upstream command handshake
//   out_valid/out_ready               head handshake toward controller
//   out_func/out_tag/out_index/out_offset/out_snoop/out_maint  decoded head
//   accepted_count/illegal_count      saturating statistics
//   level                             occupancy
module llc_cmd_queue
  import llc_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FUNCTION_SIZE-1:0]    in_func,
  input  logic [ADDRESS_SIZE-1:0]     in_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FUNCTION_SIZE-1:0]    out_func,
  output logic [TAG_SIZE-1:0]         out_tag,
  output logic [INDEX_SIZE-1:0]       out_index,
  output logic [BYTE_SELECT_SIZE-1:0] out_offset,
  output logic                        out_snoop,
  output logic                        out_maint,
  output logic [COUNTER_SIZE-1:0]     accepted_count,
  output logic [COUNTER_SIZE-1:0]     illegal_count,
  output logic [LVL_W-1:0]            level
);

  logic                    w_legal;
  logic                    w_accept;
  logic [CMD_W-1:0]        w_head;
  llc_cmd_t                w_head_cmd;
  logic [COUNTER_SIZE-1:0] r_acc_cnt;
  logic [COUNTER_SIZE-1:0] r_ill_cnt;

  function automatic logic [COUNTER_SIZE-1:0] sat_inc(input logic [COUNTER_SIZE-1:0] v);
    return (&v) ? v : v + COUNTER_SIZE'(1);
  endfunction

  assign w_legal  = is_legal_func(in_func);
  assign w_accept = in_valid && in_ready;

  // The FIFO only sees legal commands, but in_ready comes from FIFO state alone,
  // so an illegal command completes its handshake (and is dropped) only when
  // the FIFO has room, exactly like a legal one.
  llc_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (in_valid && w_legal),
    .o_push_ready (in_ready),
    .i_push_data  ({in_func, in_addr}),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_head),
    .o_level      (level)
  );

  assign w_head_cmd = split_cmd(w_head[CMD_W-1 -: FUNCTION_SIZE], w_head[ADDRESS_SIZE-1:0]);
  assign out_func   = w_head_cmd.func;
  assign out_tag    = w_head_cmd.tag;
  assign out_index  = w_head_cmd.index;
  assign out_offset = w_head_cmd.offset;
  assign out_snoop  = is_snoop_func(w_head_cmd.func);
  assign out_maint  = is_maint_func(w_head_cmd.func);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= '0;
      r_ill_cnt <= '0;
    end else if (w_accept) begin
      if (w_legal) r_acc_cnt <= sat_inc(r_acc_cnt);
      else         r_ill_cnt <= sat_inc(r_ill_cnt);
    end
  end

  assign accepted_count = r_acc_cnt;
  assign illegal_count  = r_ill_cnt;

endmodule

// File: tb/tb_llc_cmd_queue.sv
module tb_llc_cmd_queue;
  import llc_cmd_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_func;
  logic [10:0] out_tag;
  logic [14:0] out_index;
  logic [5:0]  out_offset;
  logic        out_snoop;
  logic        out_maint;
  logic [15:0] accepted_count;
  logic [15:0] illegal_count;
  logic [LVL_W-1:0] level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: an ordered list of {func, addr} and two plain counters.
  logic [35:0] mq [$];
  int          m_acc;
  int          m_ill;

  logic [74:0] act;

  llc_cmd_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_func(out_func), .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .out_snoop(out_snoop), .out_maint(out_maint),
    .accepted_count(accepted_count), .illegal_count(illegal_count), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Head fields are don't-care while out_valid=0, so they are masked to zero.
  assign act = {in_ready, out_valid, level,
                out_valid ? {out_func, out_tag, out_index, out_offset, out_snoop, out_maint} : 38'd0,
                accepted_count, illegal_count};

  function automatic logic model_legal(input int f);
    return (f <= 6) || (f == 8) || (f == 9);
  endfunction

  function automatic logic [74:0] exp_vec();
    int          f;
    logic [31:0] a;
    logic [10:0] tg;
    logic [14:0] ix;
    logic [5:0]  of;
    logic        sn, mt;
    f = 0; a = 0;
    if (mq.size() != 0) begin
      f = int'(mq[0][35:32]);
      a = mq[0][31:0];
    end
    tg = 11'(a / 32'h0020_0000);
    ix = 15'((a / 64) % 32768);
    of = 6'(a % 64);
    sn = (f >= 3) && (f <= 6);
    mt = (f == 8) || (f == 9);
    return {mq.size() < DEPTH, mq.size() != 0, 3'(mq.size()),
            4'(f), tg, ix, of, sn, mt, 16'(m_acc), 16'(m_ill)};
  endfunction

  // Drive one cycle of stimulus and advance the model across the clock edge.
  task automatic step(input logic r, input logic v, input logic [3:0] f,
                      input logic [31:0] a, input logic rd);
    logic acc, pop;
    rst = r; in_valid = v; in_func = f; in_addr = a; out_ready = rd;
    acc = v && (mq.size() < DEPTH);
    pop = rd && (mq.size() != 0);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mq.delete();
      m_acc = 0;
      m_ill = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && model_legal(int'(f))) begin
        mq.push_back({f, a});
        if (m_acc < 65535) m_acc++;
      end else if (acc) begin
        if (m_ill < 65535) m_ill++;
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  function automatic logic [3:0] rand_legal();
    logic [3:0] f;
    f = 4'($urandom_range(0, 8));
    if (f == 4'd7) f = 4'd9;
    return f;
  endfunction

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 32'hDEAD_BEEF, 1);
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_vec cyc %0d: got %h expected %h", cyc, act, exp_vec());
    end
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        accepted_count !== 16'd0 || illegal_count !== 16'd0) begin
      errors++; $display("FAIL reset_state: got lvl=%0d ov=%b ir=%b acc=%0d ill=%0d expected 0 0 1 0 0",
                         level, out_valid, in_ready, accepted_count, illegal_count);
    end
  endtask

  task automatic test_decode();
    step(1, 0, 0, 0, 0);
    step(0, 1, 4'd0, 32'h1234_5678, 0);
    checks++;
    if ({out_valid, out_tag, out_index, out_offset, out_snoop, out_maint, accepted_count} !==
        {1'b1, 11'h091, 15'h5159, 6'h38, 1'b0, 1'b0, 16'd1}) begin
      errors++; $display("FAIL decode: got v=%b tag=%h idx=%h off=%h sn=%b mt=%b acc=%0d expected 1 091 5159 38 0 0 1",
                         out_valid, out_tag, out_index, out_offset, out_snoop, out_maint, accepted_count);
    end
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL decode_vec: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_illegal_drop();
    step(1, 0, 0, 0, 0);
    step(0, 1, 4'd7, 32'h0000_1000, 0);
    checks++;
    if (out_valid !== 1'b0 || illegal_count !== 16'd1) begin
      errors++; $display("FAIL illegal_drop: got ov=%b ill=%0d expected 0 1", out_valid, illegal_count);
    end
    step(0, 1, 4'd4, 32'h0000_0040, 0);
    checks++;
    if ({level, out_func, out_index, out_snoop, illegal_count, accepted_count} !==
        {3'd1, 4'd4, 15'h0001, 1'b1, 16'd1, 16'd1}) begin
      errors++; $display("FAIL illegal_head: got lvl=%0d f=%0d idx=%h sn=%b ill=%0d acc=%0d expected 1 4 0001 1 1 1",
                         level, out_func, out_index, out_snoop, illegal_count, accepted_count);
    end
    // Maintenance code flag.
    step(0, 1, 4'd9, 32'h0, 1);
    checks++;
    if (out_func !== 4'd9 || out_maint !== 1'b1 || out_snoop !== 1'b0) begin
      errors++; $display("FAIL maint_flag: got f=%0d mt=%b sn=%b expected 9 1 0", out_func, out_maint, out_snoop);
    end
  endtask

  task automatic test_full_stall();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'd1, 32'h100 * i, 0);
    checks++;
    if (in_ready !== 1'b0 || level !== 3'd4) begin
      errors++; $display("FAIL full: got ir=%b lvl=%0d expected 0 4", in_ready, level);
    end
    step(0, 1, 4'd2, 32'hAAAA_0000, 0);
    checks++;
    if (level !== 3'd4 || accepted_count !== 16'd4) begin
      errors++; $display("FAIL full_stall: got lvl=%0d acc=%0d expected 4 4", level, accepted_count);
    end
    step(0, 1, 4'd2, 32'hAAAA_0000, 1);
    checks++;
    if (level !== 3'd3 || in_ready !== 1'b1 || accepted_count !== 16'd4 || out_addr_tag_ok(32'h100) !== 1'b1) begin
      errors++; $display("FAIL full_pop: got lvl=%0d ir=%b acc=%0d idx=%h expected 3 1 4 0004",
                         level, in_ready, accepted_count, out_index);
    end
    step(0, 1, 4'd2, 32'hAAAA_0000, 0);
    checks++;
    if (level !== 3'd4 || accepted_count !== 16'd5 || act !== exp_vec()) begin
      errors++; $display("FAIL full_refill: got lvl=%0d acc=%0d expected 4 5", level, accepted_count);
    end
  endtask

  function automatic logic out_addr_tag_ok(input logic [31:0] a);
    return (out_index == 15'((a / 64) % 32768)) && (out_tag == 11'(a / 32'h0020_0000));
  endfunction

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0);
    step(0, 1, rand_legal(), $urandom, 0);
    step(0, 1, rand_legal(), $urandom, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, rand_legal(), $urandom, 1);
      checks++;
      if (level !== 3'd2 || act !== exp_vec()) begin
        errors++; $display("FAIL back_to_back i=%0d: got lvl=%0d %h expected 2 %h", i, level, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", cyc, act, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step(0, 1, rand_legal(), $urandom, 1);
    checks++;
    if (accepted_count !== 16'hFFFF || act !== exp_vec()) begin
      errors++; $display("FAIL saturation: got acc=%h %h expected FFFF %h", accepted_count, act, exp_vec());
    end
    step(0, 1, 4'd0, 32'h0, 1);
    checks++;
    if (accepted_count !== 16'hFFFF) begin
      errors++; $display("FAIL saturation_hold: got %h expected FFFF", accepted_count);
    end
  endtask

  task automatic test_reset_midflight();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, rand_legal(), $urandom, 0);
    step(0, 1, 4'd7, 32'h0, 0);
    step(1, 1, 4'd1, 32'h5555_5555, 1);
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        accepted_count !== 16'd0 || illegal_count !== 16'd0) begin
      errors++; $display("FAIL reset_midflight: got lvl=%0d ov=%b ir=%b acc=%0d ill=%0d expected 0 0 1 0 0",
                         level, out_valid, in_ready, accepted_count, illegal_count);
    end
    step(0, 1, 4'd5, 32'h0000_0FC0, 0);
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL after_reset: got %h expected %h", act, exp_vec());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_func = '0; in_addr = '0; out_ready = 1'b0;
    m_acc = 0; m_ill = 0;
    test_reset();
    test_decode();
    test_illegal_drop();
    test_full_stall();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
